bank_read_handler: RTL
======================

# bank_read_handler

Read-side companion to the four-bank write-enable decode. It accepts one read request at a time over a valid/ready handshake and decodes the 2-bit bank select into a single-cycle one-hot bank read enable. It waits a fixed bank read latency, captures the selected bank's data and returns it over a valid/ready response channel. It sits between the bank-select/address front end and the four memory banks, alongside the write path. It holds off any read to a bank that the write path is enabling in the same cycle.

## Interface
- READ_LATENCY, 1: cycles from bank read enable to valid bank read data; legal range 1..4.
- ADDR_WIDTH, 8: per-bank word address width.
- DATA_WIDTH, 32: bank data width.

- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- req_valid  input  1  read request present.
- req_ready  output  1  block can accept a request.
- req_bank  input  2  bank select: 00 = Bank01, 01 = Bank02, 10 = Bank03, 11 = Bank04.
- req_addr  input  ADDR_WIDTH  word address within the bank.
- write_enable  input  1  write path is writing this cycle.
- write_bank_select  input  2  bank targeted by the write path.
- bank_read_enable  output  4  one-hot read enable; bit0 = Bank01 … bit3 = Bank04.
- bank_addr  output  ADDR_WIDTH  address driven to all banks.
- bank01_rdata … bank04_rdata  input  DATA_WIDTH each  bank read data.
- rsp_valid  output  1  response data valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  DATA_WIDTH  captured read data.
- rsp_bank  output  2  bank the response came from.
- busy  output  1  high in any state other than IDLE.
- stall_count  output  16  count of conflict-stall cycles; saturates at 0xFFFF.

## Operation
- State machine: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch req_bank and req_addr, then go to ISSUE.
  - No request is accepted in any other state.
- ISSUE:
  - A conflict exists when write_enable = 1 and write_bank_select equals the latched bank.
  - On conflict: bank_read_enable = 0, stay in ISSUE, and increment stall_count unless it is already 0xFFFF.
  - With no conflict: drive bank_read_enable one-hot for the latched bank for exactly this cycle, load the latency counter with READ_LATENCY, go to WAIT.
- WAIT:
  - The counter decrements each cycle.
  - In the cycle the counter equals 1, capture the latched bank's rdata into rsp_data at the clock edge and go to RESP.
- RESP:
  - rsp_valid = 1.
  - rsp_data and rsp_bank hold stable until rsp_valid && rsp_ready, then go to IDLE.
- bank_addr is registered from req_addr at acceptance and holds until the next acceptance.
- bank_read_enable is never multi-hot and never high outside ISSUE.
- The write inputs are sampled only in ISSUE.

## Timing
- Reset values (rst_n low at a rising edge):
  - state = IDLE.
  - req_ready = 1 from the first cycle after reset.
  - bank_read_enable = 0, bank_addr = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_bank = 0.
  - busy = 0, stall_count = 0, latency counter = 0.
- Reset asserted mid-operation (ISSUE, WAIT or RESP):
  - Returns to IDLE at that edge.
  - Pending response is discarded and no further enable pulse is issued.
- Cycle-level sequence, request handshake in cycle N, no conflict:
  - Enable is high in cycle N+1.
  - Data is captured at the end of cycle N+1+READ_LATENCY.
  - rsp_valid rises in cycle N+2+READ_LATENCY.
- Each conflict cycle adds exactly one cycle to that latency.
- Back-to-back requests:
  - A response handshake in cycle M returns to IDLE at M+1.
  - The next request can be accepted in cycle M+1.
  - Throughput is at most one read per READ_LATENCY+3 cycles.
- rsp_ready held low: the block stays in RESP indefinitely with data stable.
- stall_count saturates at 0xFFFF and does not wrap.

## Test plan
- Basic read, READ_LATENCY=1:
  - Stimulus: req_bank=10, req_addr=0x3C, rsp_ready=1; Bank03 returns 0xDEADBEEF.
  - Response: bank_read_enable=0100 for one cycle, bank_addr=0x3C, rsp_valid 3 cycles after the handshake, rsp_data=0xDEADBEEF, rsp_bank=10.
- All banks, READ_LATENCY=3:
  - Stimulus: one read each to banks 00, 01, 10, 11, with distinct data per bank.
  - Response: enables 0001, 0010, 0100, 1000 in turn; each rsp_valid arrives 5 cycles after its handshake.
- Write conflict:
  - Stimulus: read of bank 01 while write_enable=1 and write_bank_select=01 for 3 cycles.
  - Response: no enable during those cycles; enable=0010 in the 4th cycle; stall_count=3; a conflict on a different bank (select=11) causes no stall.
- Response backpressure:
  - Stimulus: rsp_ready=0 for 10 cycles.
  - Response: rsp_valid and rsp_data stable throughout, req_ready=0, a req_valid during that time is not accepted; rsp_ready=1 completes the response and req_ready=1 the next cycle.
- Reset mid-WAIT:
  - Stimulus: rst_n=0 for one edge during WAIT with READ_LATENCY=4.
  - Response: next cycle shows IDLE, rsp_valid=0, rsp_data=0, bank_read_enable=0, stall_count=0, and no late response appears.
- Saturation:
  - Stimulus: force 65540 conflict cycles.
  - Response: stall_count reads 0xFFFF and holds.

Source files
------------

// File: rtl/bank_read_handler.sv
// bank_read_handler: read-side companion to the four-bank write decode.
// Accepts one read request at a time, pulses a one-hot bank read enable
// (held off while the write path targets the same bank), waits the fixed
// bank read latency, captures the bank data and returns it on a
// valid/ready response channel.
module bank_read_handler #(
    parameter int READ_LATENCY = 1,   // legal range 1..4
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // request channel
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_bank,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    // write path snoop
    input  logic                  write_enable,
    input  logic [1:0]            write_bank_select,
    // bank interface
    output logic [3:0]            bank_read_enable,
    output logic [ADDR_WIDTH-1:0] bank_addr,
    input  logic [DATA_WIDTH-1:0] bank01_rdata,
    input  logic [DATA_WIDTH-1:0] bank02_rdata,
    input  logic [DATA_WIDTH-1:0] bank03_rdata,
    input  logic [DATA_WIDTH-1:0] bank04_rdata,
    // response channel
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_bank,
    // status
    output logic                  busy,
    output logic [15:0]           stall_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY);

    logic [1:0]            state;
    logic [1:0]            lat_bank;   // bank latched at request acceptance
    logic [2:0]            lat_cnt;    // remaining bank read latency
    logic                  conflict;
    logic [DATA_WIDTH-1:0] sel_rdata;

    // The write path owns the bank this cycle if it targets the latched bank.
    assign conflict  = write_enable && (write_bank_select == lat_bank);

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_RESP);

    // One-hot read enable, only in ISSUE and only when the bank is free.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        bank_read_enable = 4'b0000;
        if (state == S_ISSUE && !conflict) begin
            bank_read_enable[lat_bank] = 1'b1;
        end
    end

    // Select the latched bank's read data for capture.
    always_comb begin
        sel_rdata = bank01_rdata;
        case (lat_bank)
            2'd0:    sel_rdata = bank01_rdata;
            2'd1:    sel_rdata = bank02_rdata;
            2'd2:    sel_rdata = bank03_rdata;
            default: sel_rdata = bank04_rdata;
        endcase
    end

    // Request/issue/wait/response sequencing, stall counting and capture.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state       <= S_IDLE;
            lat_bank    <= 2'd0;
            lat_cnt     <= 3'd0;
            bank_addr   <= '0;
            rsp_data    <= '0;
            rsp_bank    <= 2'd0;
            stall_count <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_bank  <= req_bank;
                        bank_addr <= req_addr;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (conflict) begin
                        if (stall_count != 16'hFFFF) begin
                            stall_count <= stall_count + 16'd1;
                        end
                    end else begin
                        lat_cnt <= LAT_LOAD;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    if (lat_cnt == 3'd1) begin
                        rsp_data <= sel_rdata;
                        rsp_bank <= lat_bank;
                        state    <= S_RESP;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
